// File: rtl/apb_regfile_completer.sv
// APB4 completer with a small register bank, byte-strobe writes, programmable wait states
// and error signalling for misaligned, out-of-range, read-only and privileged accesses.
module apb_regfile_completer #(
    parameter int                   D_WIDTH     = 32,
    parameter int                   NUM_REGS    = 16,
    parameter int                   WAIT_CYCLES = 2,
    parameter logic [D_WIDTH-1:0]   ID_VALUE    = 32'hA0B4_0001,
    parameter logic [NUM_REGS-1:0]  PRIV_MASK   = 16'h0002
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [D_WIDTH-1:0] paddr,
    input  logic [D_WIDTH-1:0] pwdata,
    input  logic [3:0]         pstrb,
    input  logic [2:0]         pprot,
    output logic [D_WIDTH-1:0] prdata,
    output logic               pready,
    output logic               pslverr
);

    localparam int         ADDR_BITS = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int         NBYTES    = D_WIDTH / 8;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [D_WIDTH-1:0]   addr_q;
    logic [D_WIDTH-1:0]   wdata_q;
    logic [3:0]           strb_q;
    logic                 write_q;
    logic                 priv_q;
    logic [D_WIDTH-1:0]   regs [NUM_REGS];

    logic [D_WIDTH-1:0]   req_addr;
    logic                 req_write;
    logic                 req_priv;
    logic [ADDR_BITS-1:0] widx;
    logic                 in_range;
    logic                 req_err;
    logic [D_WIDTH-1:0]   rd_word;
    logic [D_WIDTH-1:0]   done_rdata;
    logic                 unused_prot;

    assign unused_prot = ^pprot[2:1];

    function automatic logic [D_WIDTH-1:0] merge_bytes(
        input logic [D_WIDTH-1:0] old_val,
        input logic [D_WIDTH-1:0] new_val,
        input logic [3:0]         strb
    );
        logic [D_WIDTH-1:0] res;
        res = old_val;
        for (int k = 0; k < NBYTES; k++) begin
            if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

    // In IDLE the live bus is decoded so a zero-wait build can answer on the next edge;
    // afterwards only the latched request matters.
    always_comb begin
        req_addr   = (state == S_IDLE) ? paddr  : addr_q;
        req_write  = (state == S_IDLE) ? pwrite : write_q;
        req_priv   = (state == S_IDLE) ? pprot[0] : priv_q;
        widx       = req_addr[ADDR_BITS+1:2];
        in_range   = (req_addr[D_WIDTH-1:2] < (D_WIDTH-2)'(NUM_REGS));
        req_err    = (req_addr[1:0] != 2'b00) || !in_range
                   || (req_write && (widx == '0))
                   || (req_write && PRIV_MASK[widx] && !req_priv);
        rd_word    = (widx == '0) ? ID_VALUE : regs[widx];
        done_rdata = (req_err || req_write) ? '0 : rd_word;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
            priv_q  <= 1'b0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (psel && !penable) begin
                        addr_q  <= paddr;
                        wdata_q <= pwdata;
                        strb_q  <= pstrb;
                        write_q <= pwrite;
                        priv_q  <= pprot[0];
                        cnt     <= WAIT_INIT;
                        if (WAIT_CYCLES == 0) begin
                            state   <= S_DONE;
                            pready  <= 1'b1;
                            pslverr <= req_err;
                            prdata  <= done_rdata;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!psel) begin
                        state <= S_IDLE;
                    end else if (cnt <= 4'd1) begin
                        state   <= S_DONE;
                        pready  <= 1'b1;
                        pslverr <= req_err;
                        prdata  <= done_rdata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // Either completion or abort returns to IDLE; only a completed clean write commits.
                    if (!psel || penable) begin
                        if (psel && write_q && !req_err)
                            regs[widx] <= merge_bytes(regs[widx], wdata_q, strb_q);
                        state   <= S_IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
